// File: rtl/sobel_magnitude.sv
// L1 Sobel gradient magnitude (|gx|+|gy|, saturated) with edge threshold and
// raster sof/eol tags, carried through two elastic valid/ready register stages.
module sobel_magnitude #(
  parameter int unsigned WIDTH_P  = 8,
  parameter int unsigned DEPTH_P  = 16,
  parameter int unsigned HEIGHT_P = 16
) (
  input  logic                        clk_i,
  input  logic                        rstn_i,
  input  logic                        valid_i,
  output logic                        ready_o,
  input  logic signed [2*WIDTH_P-1:0] gx_i,
  input  logic signed [2*WIDTH_P-1:0] gy_i,
  input  logic        [WIDTH_P-1:0]   threshold_i,
  output logic                        valid_o,
  input  logic                        ready_i,
  output logic        [WIDTH_P-1:0]   mag_o,
  output logic                        edge_o,
  output logic                        sof_o,
  output logic                        eol_o
);

  localparam int unsigned GW_C = 2 * WIDTH_P;
  localparam int unsigned CW_C = (DEPTH_P > 1) ? $clog2(DEPTH_P) : 1;
  localparam int unsigned RW_C = (HEIGHT_P > 1) ? $clog2(HEIGHT_P) : 1;
  localparam logic [CW_C-1:0] COL_LAST_C = CW_C'(DEPTH_P - 1);
  localparam logic [RW_C-1:0] ROW_LAST_C = RW_C'(HEIGHT_P - 1);
  localparam logic [GW_C:0]   MAG_MAX_C  = {{(GW_C - WIDTH_P + 1){1'b0}}, {WIDTH_P{1'b1}}};

  logic [CW_C-1:0]    col_q, col_d;
  logic [RW_C-1:0]    row_q, row_d;
  logic               v1_q, v2_q;
  logic [GW_C-1:0]    absx_q, absx_d, absy_q, absy_d;
  logic               border1_q, border1_d, sof1_q, sof1_d, eol1_q, eol1_d;
  logic [WIDTH_P-1:0] mag2_q, mag2_d;
  logic               edge2_q, edge2_d, sof2_q, eol2_q;
  logic [GW_C:0]      sum;
  logic               load1, load2, accept;

  assign load2   = ~v2_q | ready_i;
  assign load1   = ~v1_q | load2;
  assign ready_o = load1;
  assign accept  = valid_i & ready_o;

  always_comb begin
    col_d = col_q;
    row_d = row_q;
    if (accept) begin
      if (col_q == COL_LAST_C) begin
        col_d = '0;
        row_d = (row_q == ROW_LAST_C) ? '0 : row_q + 1'b1;
      end else begin
        col_d = col_q + 1'b1;
      end
    end
  end

  // Negating the most negative value wraps back to 2^(GW-1), which read as
  // unsigned is exactly its magnitude.
  always_comb begin
    absx_d    = gx_i[GW_C-1] ? GW_C'(-gx_i) : GW_C'(gx_i);
    absy_d    = gy_i[GW_C-1] ? GW_C'(-gy_i) : GW_C'(gy_i);
    border1_d = (int'(col_q) < 2) | (int'(row_q) < 2);
    sof1_d    = (col_q == '0) & (row_q == '0);
    eol1_d    = (col_q == COL_LAST_C);
  end

  always_comb begin
    sum     = {1'b0, absx_q} + {1'b0, absy_q};
    mag2_d  = (sum > MAG_MAX_C) ? '1 : sum[WIDTH_P-1:0];
    edge2_d = (mag2_d >= threshold_i);
    if (border1_q) begin
      mag2_d  = '0;
      edge2_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      col_q     <= '0;
      row_q     <= '0;
      v1_q      <= 1'b0;
      v2_q      <= 1'b0;
      absx_q    <= '0;
      absy_q    <= '0;
      border1_q <= 1'b0;
      sof1_q    <= 1'b0;
      eol1_q    <= 1'b0;
      mag2_q    <= '0;
      edge2_q   <= 1'b0;
      sof2_q    <= 1'b0;
      eol2_q    <= 1'b0;
    end else begin
      col_q <= col_d;
      row_q <= row_d;
      if (load1) begin
        v1_q <= valid_i;
        if (valid_i) begin
          absx_q    <= absx_d;
          absy_q    <= absy_d;
          border1_q <= border1_d;
          sof1_q    <= sof1_d;
          eol1_q    <= eol1_d;
        end
      end
      if (load2) begin
        v2_q <= v1_q;
        if (v1_q) begin
          mag2_q  <= mag2_d;
          edge2_q <= edge2_d;
          sof2_q  <= sof1_q;
          eol2_q  <= eol1_q;
        end
      end
    end
  end

  assign valid_o = v2_q;
  assign mag_o   = mag2_q;
  assign edge_o  = edge2_q;
  assign sof_o   = sof2_q;
  assign eol_o   = eol2_q;

endmodule

// File: tb/tb_sobel_magnitude.sv
// Self-checking bench for sobel_magnitude: vector table, hand sequences for
// backpressure/threshold/reset, and random traffic against a reference model.
module tb_sobel_magnitude;

  localparam int W = 8;
  localparam int D = 16;
  localparam int H = 16;

  logic                  clk = 1'b0;
  logic                  rstn;
  logic                  valid_i, ready_o, valid_o, ready_i;
  logic                  edge_o, sof_o, eol_o;
  logic signed [2*W-1:0] gx_i, gy_i;
  logic        [W-1:0]   threshold_i, mag_o;

  always #5 clk = ~clk;

  sobel_magnitude #(.WIDTH_P(W), .DEPTH_P(D), .HEIGHT_P(H)) dut (
    .clk_i      (clk),
    .rstn_i     (rstn),
    .valid_i    (valid_i),
    .ready_o    (ready_o),
    .gx_i       (gx_i),
    .gy_i       (gy_i),
    .threshold_i(threshold_i),
    .valid_o    (valid_o),
    .ready_i    (ready_i),
    .mag_o      (mag_o),
    .edge_o     (edge_o),
    .sof_o      (sof_o),
    .eol_o      (eol_o)
  );

  typedef struct {
    logic [7:0] mag;
    logic       edg;
    logic       sof;
    logic       eol;
    int         cyc;
    logic       strict;
  } exp_t;

  typedef struct {
    logic signed [15:0] gx;
    logic signed [15:0] gy;
    logic [7:0]         thr;
    logic [7:0]         mag;
    logic               edg;
  } vec_t;

  exp_t       sb[$];
  vec_t       tab[12];
  int         n_pass = 0, n_tot = 0;
  int         cyc = 0, acc_n = 0, res_n = 0, n_sof = 0, n_eol = 0;
  logic       strict = 1'b0, ovr = 1'b0, ovr_edge = 1'b0;
  logic [7:0] ovr_mag = 8'd0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_tot++;
    if (act === req) n_pass++;
    else $display("FAIL %s: got %0h required %0h", name, act, req);
  endtask

  // Reference: position from accept count, magnitude from plain integer math.
  function automatic exp_t model(input int n, input logic signed [15:0] gx,
                                 input logic signed [15:0] gy, input int thr);
    exp_t e;
    int ax, ay, s, col, row;
    ax  = (gx < 0) ? -int'(gx) : int'(gx);
    ay  = (gy < 0) ? -int'(gy) : int'(gy);
    s   = ax + ay;
    col = n % D;
    row = (n / D) % H;
    e.mag = (s > 255) ? 8'd255 : 8'(s);
    e.edg = (int'(e.mag) >= thr);
    if (col < 2 || row < 2) begin
      e.mag = 8'd0;
      e.edg = 1'b0;
    end
    e.sof    = (col == 0 && row == 0);
    e.eol    = (col == D - 1);
    e.cyc    = 0;
    e.strict = 1'b0;
    return e;
  endfunction

  // Called at a negedge with inputs already set; checks any popped result,
  // records any accepted pair, then advances to the next negedge.
  task automatic cycle(output logic acc);
    exp_t       e;
    logic [7:0] lat;
    #1;
    if (valid_o && ready_i) begin
      if (sb.size() == 0) begin
        n_tot++;
        $display("FAIL spurious_result: got valid_o=1 mag=%0d required no pending result", mag_o);
      end else begin
        e   = sb.pop_front();
        lat = e.strict ? 8'(cyc - e.cyc) : 8'd2;
        check($sformatf("result%0d{mag,edge,sof,eol,lat}", res_n),
              {mag_o, edge_o, sof_o, eol_o, lat}, {e.mag, e.edg, e.sof, e.eol, 8'd2});
      end
      if (sof_o) n_sof++;
      if (eol_o) n_eol++;
      res_n++;
    end
    acc = valid_i && ready_o;
    if (acc) begin
      e = model(acc_n, gx_i, gy_i, int'(threshold_i));
      if (ovr) begin
        e.mag = ovr_mag;
        e.edg = ovr_edge;
      end
      e.cyc    = cyc;
      e.strict = strict;
      sb.push_back(e);
      acc_n++;
    end
    @(posedge clk);
    cyc++;
    @(negedge clk);
  endtask

  task automatic send(input logic signed [15:0] gx, input logic signed [15:0] gy);
    logic acc;
    int   k;
    k     = 0;
    gx_i  = gx;
    gy_i  = gy;
    valid_i = 1'b1;
    do begin
      cycle(acc);
      k++;
    end while (!acc && k < 200);
    if (!acc) check("send_timeout", 64'd0, 64'd1);
    valid_i = 1'b0;
  endtask

  task automatic drain();
    logic acc;
    int   k;
    k       = 0;
    valid_i = 1'b0;
    ready_i = 1'b1;
    while (sb.size() != 0 && k < 100) begin
      cycle(acc);
      k++;
    end
    repeat (2) cycle(acc);
    check("drain_empty", 64'(sb.size()), 64'd0);
  endtask

  task automatic do_reset();
    valid_i = 1'b0;
    ready_i = 1'b1;
    #2 rstn = 1'b0;
    #1 check("reset_outputs{valid,mag,edge,sof,eol,ready}",
             {valid_o, mag_o, edge_o, sof_o, eol_o, ready_o}, {1'b0, 8'd0, 4'b0001});
    @(negedge clk);
    rstn = 1'b1;
    sb.delete();
    acc_n = 0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation still running at %0t, required completion", $time);
    $fatal(1);
  end

  initial begin
    logic        acc;
    logic [11:0] snap;
    int          sent, k;

    tab[0]  = '{16'sd3,      -16'sd4,     8'd5,   8'd7,   1'b1};
    tab[1]  = '{16'sd3,      -16'sd4,     8'd8,   8'd7,   1'b0};
    tab[2]  = '{16'sd200,    16'sd100,    8'd5,   8'd255, 1'b1};
    tab[3]  = '{-16'sd32768, 16'sd0,      8'd255, 8'd255, 1'b1};
    tab[4]  = '{16'sd0,      -16'sd1,     8'd1,   8'd1,   1'b1};
    tab[5]  = '{16'sd0,      -16'sd1,     8'd2,   8'd1,   1'b0};
    tab[6]  = '{16'sd0,      16'sd0,      8'd0,   8'd0,   1'b1};
    tab[7]  = '{16'sd127,    16'sd128,    8'd255, 8'd255, 1'b1};
    tab[8]  = '{16'sd100,    -16'sd50,    8'd150, 8'd150, 1'b1};
    tab[9]  = '{16'sd100,    -16'sd50,    8'd151, 8'd150, 1'b0};
    tab[10] = '{16'sd32767,  -16'sd32768, 8'd0,   8'd255, 1'b1};
    tab[11] = '{-16'sd255,   16'sd0,      8'd200, 8'd255, 1'b1};

    rstn = 1'b1; valid_i = 1'b0; ready_i = 1'b1;
    gx_i = '0; gy_i = '0; threshold_i = 8'd5;
    do_reset();

    // Basic stream clears the border, then table vectors land on interior pixels.
    strict = 1'b1;
    threshold_i = 8'd5;
    for (int i = 0; i < 34; i++) send(16'sd3, -16'sd4);
    drain();
    for (int i = 0; i < 12; i++) begin
      threshold_i = tab[i].thr;
      ovr = 1'b1; ovr_mag = tab[i].mag; ovr_edge = tab[i].edg;
      send(tab[i].gx, tab[i].gy);
      ovr = 1'b0;
      drain();
    end

    // Threshold is taken when the pair enters stage 2, not when it is accepted.
    threshold_i = 8'd5; ovr = 1'b1; ovr_mag = 8'd7; ovr_edge = 1'b0;
    gx_i = 16'sd3; gy_i = -16'sd4; valid_i = 1'b1;
    cycle(acc);
    check("thr_late_acc", {63'd0, acc}, 64'd1);
    valid_i = 1'b0; threshold_i = 8'd8;
    cycle(acc);
    ovr_edge = 1'b1; valid_i = 1'b1;
    cycle(acc);
    check("thr_late2_acc", {63'd0, acc}, 64'd1);
    valid_i = 1'b0; threshold_i = 8'd5;
    cycle(acc);
    ovr = 1'b0;
    drain();

    // Backpressure: exactly two absorbed, outputs held, ready_o returns combinationally.
    strict = 1'b0;
    ready_i = 1'b0; valid_i = 1'b1; gx_i = 16'sd3; gy_i = -16'sd4;
    cycle(acc);
    check("bp_acc_first", {63'd0, acc}, 64'd1);
    gx_i = 16'sd200; gy_i = 16'sd100;
    cycle(acc);
    check("bp_acc_second", {63'd0, acc}, 64'd1);
    gx_i = 16'sd0; gy_i = -16'sd1;
    cycle(acc);
    check("bp_blocked{acc,ready_o}", {62'd0, acc, ready_o}, 64'd0);
    snap = {valid_o, mag_o, edge_o, sof_o, eol_o};
    cycle(acc);
    cycle(acc);
    check("bp_hold{valid,mag,edge,sof,eol,acc}",
          {valid_o, mag_o, edge_o, sof_o, eol_o, acc}, {snap[11], snap[10:0], 1'b0});
    ready_i = 1'b1;
    #1 check("bp_ready_comb", {63'd0, ready_o}, 64'd1);
    cycle(acc);
    check("bp_acc_third", {63'd0, acc}, 64'd1);
    valid_i = 1'b0;
    drain();

    // Random traffic and random backpressure against the scoreboard.
    threshold_i = 8'd100;
    sent = 0; k = 0;
    while (sent < 1000 && k < 20000) begin
      ready_i = ($urandom_range(0, 3) != 0);
      if (!valid_i && $urandom_range(0, 3) != 0) begin
        valid_i = 1'b1;
        if ($urandom_range(0, 3) == 0) begin
          gx_i = 16'($urandom);
          gy_i = 16'($urandom);
        end else begin
          gx_i = 16'(int'($urandom_range(0, 300)) - 150);
          gy_i = 16'(int'($urandom_range(0, 300)) - 150);
        end
      end
      cycle(acc);
      if (acc) begin
        sent++;
        valid_i = 1'b0;
      end
      k++;
    end
    check("rand_sent", 64'(sent), 64'd1000);
    drain();

    // Frame tags and border over one full frame plus one pixel.
    do_reset();
    strict = 1'b1;
    threshold_i = 8'd1;
    n_sof = 0; n_eol = 0;
    for (int i = 0; i < 257; i++) send(16'sd10, 16'sd0);
    drain();
    check("frame_sof_count", 64'(n_sof), 64'd2);
    check("frame_eol_count", 64'(n_eol), 64'd16);

    // Asynchronous reset with a full, stalled pipe mid-frame.
    for (int i = 0; i < 40; i++) send(16'sd10, 16'sd0);
    drain();
    ready_i = 1'b0;
    send(16'sd10, 16'sd0);
    send(16'sd10, 16'sd0);
    check("prereset{valid,mag}", {valid_o, mag_o}, {1'b1, 8'd10});
    #2 rstn = 1'b0;
    #1 check("async_reset{valid,mag,edge,sof,eol,ready}",
             {valid_o, mag_o, edge_o, sof_o, eol_o, ready_o}, {1'b0, 8'd0, 4'b0001});
    sb.delete();
    acc_n = 0;
    #1 rstn = 1'b1;
    @(negedge clk);
    ready_i = 1'b1;
    n_sof = 0;
    for (int i = 0; i < 40; i++) send(16'sd10, 16'sd0);
    drain();
    check("post_reset_sof_count", 64'(n_sof), 64'd1);

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule

// File: doc/sobel_magnitude.md
# sobel_magnitude

Downstream stage of the 2D Sobel convolution. It consumes the signed horizontal and vertical gradient stream and computes an L1 gradient magnitude, |gx| + |gy|, saturated to the pixel width. It thresholds that magnitude into an edge flag and tags each result with raster position markers. It sits between the convolution stage and the output pixel sink, with valid/ready handshakes on both sides.

## Interface
- WIDTH_P, 8: pixel width; gradients are 2*WIDTH_P bits signed.
- DEPTH_P, 16: pixels per line; must equal the convolution stage's DEPTH_P.
- HEIGHT_P, 16: lines per frame.

Ports:
- clk_i  input  1  clock; all state updates on posedge.
- rstn_i  input  1  reset; asynchronous, active-low.
- valid_i  input  1  gradient pair valid.
- ready_o  output  1  block can accept a gradient pair.
- gx_i  input  2*WIDTH_P signed  horizontal gradient.
- gy_i  input  2*WIDTH_P signed  vertical gradient.
- threshold_i  input  WIDTH_P  edge threshold, unsigned.
- valid_o  output  1  result valid.
- ready_i  input  1  downstream can accept a result.
- mag_o  output  WIDTH_P  saturated magnitude.
- edge_o  output  1  magnitude >= threshold.
- sof_o  output  1  result is pixel (row 0, col 0).
- eol_o  output  1  result is the last pixel of a line (col DEPTH_P-1).

## Operation
- Input handshake: a pair is accepted on a cycle with valid_i & ready_o.
- Results are emitted one per accepted pair, in raster order. Column/row position is defined by the accept count.
- Position counters:
  - col runs 0..DEPTH_P-1 and advances on each input accept.
  - When col wraps to 0, row advances; row runs 0..HEIGHT_P-1 and wraps to 0.
  - The counters are captured as tags together with the data.
- Stage 1 register holds:
  - abs_x = |gx_i| and abs_y = |gy_i|, each 2*WIDTH_P bits unsigned. Abs of the most negative value (-2^(2*WIDTH_P-1)) is represented exactly as 2^(2*WIDTH_P-1), with no wrap.
  - border = (col < 2) | (row < 2).
  - sof = (col==0 & row==0).
  - eol = (col==DEPTH_P-1).
- Stage 2 register holds:
  - sum = abs_x + abs_y at 2*WIDTH_P+1 bits.
  - mag = 2^WIDTH_P-1 if sum > 2^WIDTH_P-1, else sum[WIDTH_P-1:0].
  - If border=1, mag is 0 and edge is 0; otherwise edge = (mag >= threshold_i).
  - threshold_i is sampled when stage 2 loads.
  - sof and eol tags pass through unchanged.
- Border rule: windows in columns 0-1 and rows 0-1 are not fully inside the frame, so they always produce mag 0 and edge 0. The result is still emitted.
- Each stage is an elastic register:
  - load_k = ~valid_k | ready_into_next.
  - ready_o = ~valid_1 | ~valid_2 | ready_i.
  - Data and tags load only when load_k is high and upstream valid is present.
- No result is dropped, duplicated or reordered.

## Timing
- Reset (rstn_i low, asynchronous): valid_o=0, mag_o=0, edge_o=0, sof_o=0, eol_o=0, both stage valids 0, col=0, row=0.
- Outputs reach reset values without a clock edge. ready_o is 1 once the stage valids are 0.
- Latency: a pair accepted at edge N is on the outputs after edge N+1 (two register stages) when ready_i is high.
- Throughput is one result per cycle with ready_i held high.
- Backpressure:
  - With ready_i low, the block absorbs exactly 2 pairs, then ready_o drops.
  - ready_o rises combinationally in the cycle ready_i rises.
  - Outputs are held stable while valid_o & ~ready_i.
- A simultaneous output pop and input push on a full pipe is accepted in the same cycle, with no bubble.
- Counter wrap: accept number DEPTH_P*HEIGHT_P (0-based) is tagged row 0, col 0 again, so sof_o repeats once per frame.
- Reset mid-frame: in-flight results are discarded. The first accept after release is tagged sof.
- threshold_i changes affect only pairs loaded into stage 2 after the change.

## Test plan
- Basic: DEPTH_P=16, HEIGHT_P=16, ready_i=1, threshold 5. Send 34 pairs (gx=3, gy=-4) to clear the borders.
  - Results with row≥2 and col≥2 show mag_o=7, edge_o=1, each 2 cycles after its accept.
  - With threshold 8, the same results show edge_o=0.
- Saturation/extremes: gx=200, gy=100 gives mag_o=255. gx=-32768, gy=0 gives mag_o=255. gx=0, gy=-1 gives mag_o=1, all at interior positions.
- Backpressure: hold ready_i=0 and drive 3 pairs.
  - Exactly 2 are accepted and ready_o falls.
  - On ready_i=1, results emerge in order and the third pair is accepted that cycle.
  - Random ready_i over 1000 pairs shows no loss or reordering against a scoreboard.
- Frame tags/border: stream 257 pairs with gx=10, gy=0, threshold 1.
  - sof_o on results 0 and 256.
  - eol_o on results 15, 31, …, 255.
  - mag_o=0 and edge_o=0 for rows 0-1 and columns 0-1; mag_o=10 and edge_o=1 elsewhere.
- Async reset: drop rstn_i mid-frame between clock edges.
  - valid_o and mag_o go to 0 immediately.
  - After release, the first result carries sof_o=1 and the border rule restarts at row 0.
